// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle UI events: press, release,
// short click, double click, long press and auto-repeat while held.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_in,
  input  logic in_active_low,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : CNT_ZERO;
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? CW'(REPEAT_CYCLES - 1) : CNT_ZERO;
  localparam logic          GAP_EN    = (GAP_CYCLES > 0);
  localparam logic          REP_EN    = (REPEAT_CYCLES > 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_LONG   = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  logic          btn_s_q, btn_s_d;
  logic          btn_p_q, btn_p_d;
  logic          rise_s, fall_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // FSM decision strobes, registered alongside the state
  logic ev_press_q,   ev_press_d;
  logic ev_release_q, ev_release_d;
  logic ev_short_q,   ev_short_d;
  logic ev_double_q,  ev_double_d;
  logic ev_long_q,    ev_long_d;
  logic ev_repeat_q,  ev_repeat_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic short_q,   short_d;
  logic double_q,  double_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic held_q,    held_d;

  // Polarity correction and edge-detect pipeline inputs
  always_comb begin
    btn_s_d = btn_in ^ in_active_low;
    btn_p_d = btn_s_q;
    rise_s  = btn_s_q & ~btn_p_q;
    fall_s  = ~btn_s_q & btn_p_q;
  end

  // Event FSM: next state, counter and event strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ev_press_d   = 1'b0;
    ev_release_d = 1'b0;
    ev_short_d   = 1'b0;
    ev_double_d  = 1'b0;
    ev_long_d    = 1'b0;
    ev_repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d    = ST_PRESS1;
          cnt_d      = CNT_ZERO;
          ev_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PRESS1: begin
        // A release on the threshold cycle wins over long_press
        if (fall_s) begin
          ev_release_d = 1'b1;
          cnt_d        = CNT_ZERO;
          if (GAP_EN) begin
            state_d = ST_GAP;
          end else begin
            state_d    = ST_IDLE;
            ev_short_d = 1'b1;
          end
        end else if (cnt_q == LONG_LAST) begin
          state_d   = ST_LONG;
          cnt_d     = CNT_ZERO;
          ev_long_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          state_d      = ST_IDLE;
          cnt_d        = CNT_ZERO;
          ev_release_d = 1'b1;
        end else if (!REP_EN) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == REP_LAST) begin
          cnt_d       = CNT_ZERO;
          ev_repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        // A second press on the timeout cycle still counts as a double click
        if (rise_s) begin
          state_d     = ST_PRESS2;
          cnt_d       = CNT_ZERO;
          ev_press_d  = 1'b1;
          ev_double_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          ev_short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESS2: begin
        if (fall_s) begin
          state_d      = ST_IDLE;
          cnt_d        = CNT_ZERO;
          ev_release_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output stage inputs
  always_comb begin
    press_d   = ev_press_q;
    release_d = ev_release_q;
    short_d   = ev_short_q;
    double_d  = ev_double_q;
    long_d    = ev_long_q;
    repeat_d  = ev_repeat_q;
    held_d    = (state_q == ST_PRESS1) || (state_q == ST_LONG) || (state_q == ST_PRESS2);
  end

  // Input pipeline, FSM state and counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_s_q <= 1'b0;
      btn_p_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      btn_s_q <= btn_s_d;
      btn_p_q <= btn_p_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered event strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ev_press_q   <= 1'b0;
      ev_release_q <= 1'b0;
      ev_short_q   <= 1'b0;
      ev_double_q  <= 1'b0;
      ev_long_q    <= 1'b0;
      ev_repeat_q  <= 1'b0;
    end else begin
      ev_press_q   <= ev_press_d;
      ev_release_q <= ev_release_d;
      ev_short_q   <= ev_short_d;
      ev_double_q  <= ev_double_d;
      ev_long_q    <= ev_long_d;
      ev_repeat_q  <= ev_repeat_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: stimulus pushes expected (cycle, event) pairs, a monitor
// pops and compares every time any pulse output is high.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic n_rst;
  logic btn_in;
  logic in_active_low;
  logic press_pulse, release_pulse, short_click, double_click;
  logic long_press, repeat_pulse, held;

  localparam logic [5:0] EV_PRESS = 6'b000001;
  localparam logic [5:0] EV_REL   = 6'b000010;
  localparam logic [5:0] EV_SHORT = 6'b000100;
  localparam logic [5:0] EV_DBL   = 6'b001000;
  localparam logic [5:0] EV_LONG  = 6'b010000;
  localparam logic [5:0] EV_REP   = 6'b100000;

  typedef struct {
    int         at;
    logic [5:0] ev;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         t0;
  logic [5:0] mon_vec;
  exp_t       mon_e;

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .GAP_CYCLES   (5),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .btn_in       (btn_in),
    .in_active_low(in_active_low),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every visible pulse must match the next scoreboard entry
  always @(negedge clk) begin
    mon_vec = {repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse};
    if (mon_vec != 6'b000000) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: cycle %0d got %b, wanted no pulse", cyc, mon_vec);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.at != cyc || mon_e.ev != mon_vec) begin
          miscompares++;
          $display("FAIL event: got %b at cycle %0d, wanted %b at cycle %0d",
                   mon_vec, cyc, mon_e.ev, mon_e.at);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [5:0] ev);
    exp_t e;
    e.at = at;
    e.ev = ev;
    sb.push_back(e);
  endtask

  task automatic set_btn(input logic lvl);
    btn_in = lvl ^ in_active_low;
  endtask

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, wanted %b", name, act, want);
    end
  endtask

  function automatic logic [6:0] all_outs();
    return {held, repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse};
  endfunction

  initial begin
    n_rst = 1'b0;
    btn_in = 1'b0;
    in_active_low = 1'b0;
    wait_neg(3);
    check7("reset_outputs", all_outs(), 7'b0000000);
    n_rst = 1'b1;
    wait_neg(3);

    // Short press then silence: short_click 5 cycles after release
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    wait_neg(3);
    check7("held_press1", {6'b000000, held}, 7'b0000001);
    set_btn(1'b0);
    push(t0 + 6, EV_REL);
    push(t0 + 11, EV_SHORT);
    wait_neg(12);
    check7("held_idle", {6'b000000, held}, 7'b0000000);

    // Double click
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    wait_neg(3);
    set_btn(1'b0);
    push(t0 + 6, EV_REL);
    wait_neg(2);
    set_btn(1'b1);
    push(t0 + 8, EV_PRESS | EV_DBL);
    wait_neg(3);
    set_btn(1'b0);
    push(t0 + 11, EV_REL);
    wait_neg(12);

    // Long hold with two repeats
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    push(t0 + 11, EV_LONG);
    push(t0 + 15, EV_REP);
    push(t0 + 19, EV_REP);
    wait_neg(12);
    check7("held_long", {6'b000000, held}, 7'b0000001);
    wait_neg(6);
    set_btn(1'b0);
    push(t0 + 21, EV_REL);
    wait_neg(12);

    // Release lands on the long threshold cycle: release wins, then GAP timeout
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    wait_neg(8);
    set_btn(1'b0);
    push(t0 + 11, EV_REL);
    push(t0 + 16, EV_SHORT);
    wait_neg(12);

    // Second press on the gap timeout cycle: double click wins
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    wait_neg(3);
    set_btn(1'b0);
    push(t0 + 6, EV_REL);
    wait_neg(5);
    set_btn(1'b1);
    push(t0 + 11, EV_PRESS | EV_DBL);
    wait_neg(3);
    set_btn(1'b0);
    push(t0 + 14, EV_REL);
    wait_neg(12);

    // Active-low input: idle high, low pulse of 3 cycles
    in_active_low = 1'b1;
    btn_in = 1'b1;
    wait_neg(5);
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    wait_neg(3);
    set_btn(1'b0);
    push(t0 + 6, EV_REL);
    push(t0 + 11, EV_SHORT);
    wait_neg(12);

    // Reset while in LONG, button held through reset release
    t0 = cyc;
    set_btn(1'b1);
    push(t0 + 3, EV_PRESS);
    push(t0 + 11, EV_LONG);
    wait_neg(14);
    check7("held_before_reset", all_outs(), 7'b1000000);
    #2;
    n_rst = 1'b0;
    #1;
    check7("async_reset_outputs", all_outs(), 7'b0000000);
    wait_neg(2);
    n_rst = 1'b1;
    t0 = cyc;
    push(t0 + 3, EV_PRESS);
    wait_neg(3);
    check7("held_after_reset", {6'b000000, held}, 7'b0000001);
    set_btn(1'b0);
    push(t0 + 6, EV_REL);
    push(t0 + 11, EV_SHORT);
    wait_neg(12);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d events left unseen, wanted 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
